fifo_write_arbiter: RTL
=======================

// Module: fifo_write_arbiter
// PURPOSE
//  Round-robin arbiter that shares one write port of the single-clock FIFO
//  (put/data_in/full/fillcount) between N requesters, e.g. host write ports
//  feeding the DDR2 command/write-data queue. Grants whole bursts of BURST_LEN
//  words so one requester's burst lands contiguously in the FIFO.
// PARAMETERS
//  N         4  number of requesters (2..8)
//  WIDTH     8  data word width, equal to the FIFO WIDTH
//  DEPTH_P2  6  log2 of the FIFO depth, equal to the FIFO DEPTH_P2
//  BURST_LEN 4  words per granted burst (1..2**DEPTH_P2)
// PORTS
//  clk            in  1              clock, rising edge
//  reset          in  1              synchronous, active-high
//  req            in  N              req[i]: requester i has a burst pending / holds its burst
//  req_data       in  N*WIDTH        word of requester i on bits [i*WIDTH +: WIDTH]
//  gnt            out N              one-hot burst owner, registered; 0 when idle
//  ack            out N              ack[i]=1: current word of requester i written this cycle
//  fifo_put       out 1              to FIFO put
//  fifo_data_in   out WIDTH          to FIFO data_in
//  fifo_full      in  1              from FIFO full
//  fifo_fillcount in  DEPTH_P2+1     from FIFO fillcount
//  busy           out 1              1 while in BURST
// BEHAVIOUR
//  - Reset: state=IDLE, gnt=0, busy=0, word count=0, last_owner=N-1 (req 0 wins first);
//    ack=0, fifo_put=0 combinationally while reset is high. Reset mid-burst aborts it;
//    words already put remain in the FIFO.
//  - FSM IDLE: if req!=0 (and gate passes, see CONFIGURATION), pick the first set req
//    scanning last_owner+1, +2, ... modulo N; next cycle gnt=onehot(owner), busy=1,
//    state=BURST, cnt=0. No put in IDLE. Latency req->gnt = 1 cycle.
//  - FSM BURST: fifo_put = req[owner] & ~fifo_full; fifo_data_in = req_data[owner slice]
//    (driven whenever in BURST, value don't-care when put=0);
//    ack = fifo_put ? gnt : 0. On each put cnt increments.
//  - Burst end: put with cnt==BURST_LEN-1 -> next cycle IDLE, gnt=0, busy=0,
//    last_owner=owner. Re-arbitration in the IDLE cycle; the same requester may win again
//    only if no other req is set (fairness).
//  - fifo_full in BURST: stall, no put, no ack, cnt held, gnt held; resume when full drops.
//  - Owner drops req mid-burst: no put that cycle; burst aborted -> IDLE next cycle,
//    last_owner=owner, cnt=0. Short bursts are allowed but are never padded.
//  - Requester handshake: present word k while gnt[i]; advance to word k+1 on the cycle after
//    ack[i]. req of non-owners ignored until IDLE.
//  - cnt width clog2(BURST_LEN)+1; last_owner width clog2(N), wraps N-1 -> 0.
//  - At most one gnt bit and one ack bit set in any cycle; fifo_put never high when fifo_full.
// CONFIGURATION
//  ARB_FIFO_ROOM_GATE_EN defined: IDLE grants only when
//    (2**DEPTH_P2 - fifo_fillcount) >= BURST_LEN, so a granted burst never stalls on full
//    (this block is the sole FIFO writer). Otherwise stay IDLE, gnt=0.
//  Not defined: grant regardless of fillcount; bursts may stall on fifo_full as above.
// TESTING (N=4, WIDTH=8, DEPTH_P2=3, BURST_LEN=4, FIFO instantiated behind)
//  1 reset, req=4'b0001, data 0x10..0x13 -> gnt=0001 one cycle later, 4 puts back-to-back,
//    FIFO pops 0x10,0x11,0x12,0x13, busy low after 5 cycles total.
//  2 req=4'b1111 held, 16 bursts -> owner order 0,1,2,3,0,... ; each burst's 4 words
//    contiguous in FIFO, with no interleaving.
//  3 FIFO pre-filled to 6/8, req=0001, no gate -> 2 puts, stall with gnt held while full,
//    pop 1 word -> 1 more put, pop -> last put; ack count = 4 exactly.
//  4 same as 3 with ARB_FIFO_ROOM_GATE_EN -> gnt stays 0 until fillcount<=4, then 4
//    uninterrupted puts.
//  5 req[2] drops after 2 acks -> 2 words in FIFO, IDLE next cycle, next grant goes to req 3
//    if set, else req 0.
//  6 reset asserted mid-burst after 1 put -> gnt=0, put=0 in the reset cycle; after release,
//    req 0 wins first.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
//   Round-robin burst arbiter sharing one write port of a single-clock FIFO
//   between N requesters. A grant covers a whole burst of BURST_LEN words so
//   each requester's burst lands contiguously in the FIFO.
//
//   Optional feature macro: ARB_FIFO_ROOM_GATE_EN
//     defined   : a burst is granted only when the FIFO already has room for
//                 all BURST_LEN words, so a granted burst never stalls on full.
//     undefined : grant regardless of fill level; bursts stall on fifo_full.
//
//   Reset is synchronous and active-high. While reset is high, fifo_put, ack
//   and gnt are forced low combinationally. Words already written stay in the
//   FIFO.
module fifo_write_arbiter #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH_P2  = 6,
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   req_data,
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         ack,
  output logic                 fifo_put,
  output logic [WIDTH-1:0]     fifo_data_in,
  input  logic                 fifo_full,
  input  logic [DEPTH_P2:0]    fifo_fillcount,
  output logic                 busy
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_owner_q, last_owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             busy_q, busy_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             room_ok;
  logic             in_burst;
  logic             owner_req;
  logic             put;

  // Room gate: only grant when the whole burst fits without hitting full.
`ifdef ARB_FIFO_ROOM_GATE_EN
  localparam int FIFO_DEPTH = 1 << DEPTH_P2;
  assign room_ok = (int'(fifo_fillcount) + BURST_LEN) <= FIFO_DEPTH;
`else
  logic fillcount_unused;
  assign fillcount_unused = ^fifo_fillcount;
  assign room_ok          = 1'b1;
`endif

  assign in_burst  = (state_q == BURST);
  assign owner_req = req[owner_q];
  // Reset masks the write strobe so an aborted burst writes nothing more.
  assign put       = in_burst & owner_req & ~fifo_full & ~reset;

  assign fifo_put     = put;
  assign ack          = put ? gnt_q : '0;
  assign gnt          = reset ? '0 : gnt_q;
  assign busy         = busy_q;
  assign fifo_data_in = in_burst ? req_data[owner_q*WIDTH +: WIDTH] : '0;

  // Round-robin pick: first set req scanning last_owner+1, +2, ... mod N.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      logic [IDX_W-1:0] idx;
      idx = IDX_W'((int'(last_owner_q) + k) % N);
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = idx;
      end
    end
  end

  // Next-state logic: grant in IDLE, count words and end or abort in BURST.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    busy_d       = busy_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid && room_ok) begin
          state_d = BURST;
          owner_d = pick_idx;
          gnt_d   = N'(1) << pick_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end

      BURST: begin
        if (!owner_req) begin
          // Owner withdrew: abort the short burst, nothing is padded.
          state_d      = IDLE;
          gnt_d        = '0;
          busy_d       = 1'b0;
          cnt_d        = '0;
          last_owner_d = owner_q;
        end else if (put) begin
          if (cnt_q == CNT_LAST) begin
            state_d      = IDLE;
            gnt_d        = '0;
            busy_d       = 1'b0;
            cnt_d        = '0;
            last_owner_d = owner_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // Otherwise fifo_full stalls the burst: all state held.
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State register with synchronous active-high reset; req 0 wins first.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(N - 1);
      cnt_q        <= '0;
      gnt_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      busy_q       <= busy_d;
    end
  end

endmodule
